// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared state encoding, default widths and index helper for the system bus arbiter
package sysbus_pkg;

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_ADDR_WIDTH = 32;

    function automatic int unsigned oh2idx(input logic [31:0] oh);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if (oh[i]) r = i;
        return r;
    endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// sysbus_arbiter_if: cache-side request/invalidate ports plus the shared memory port
interface sysbus_arbiter_if
    import sysbus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    localparam int MASKW = WIDTH / 8
);

    logic [NUM_MASTERS-1:0]            m_rw_valid;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_rw_addr;
    logic [NUM_MASTERS-1:0]            m_rw_we;
    logic [NUM_MASTERS*MASKW-1:0]      m_w_mask;
    logic [NUM_MASTERS*WIDTH-1:0]      m_w_data;
    logic [NUM_MASTERS-1:0]            m_w_ce;
    logic [NUM_MASTERS-1:0]            m_rw_ready;
    logic [WIDTH-1:0]                  m_r_data;
    logic [NUM_MASTERS-1:0]            m_inv_valid;
    logic [ADDR_WIDTH-1:0]             m_inv_addr;
    logic [NUM_MASTERS-1:0]            m_inv_ready;
    logic                              mem_valid;
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic                              mem_we;
    logic [MASKW-1:0]                  mem_mask;
    logic [WIDTH-1:0]                  mem_wdata;
    logic                              mem_ce;
    logic                              mem_ready;
    logic [WIDTH-1:0]                  mem_rdata;

    modport slave (
        input  m_rw_valid, m_rw_addr, m_rw_we, m_w_mask, m_w_data, m_w_ce, m_inv_ready,
        input  mem_ready, mem_rdata,
        output m_rw_ready, m_r_data, m_inv_valid, m_inv_addr,
        output mem_valid, mem_addr, mem_we, mem_mask, mem_wdata, mem_ce
    );

    modport master (
        output m_rw_valid, m_rw_addr, m_rw_we, m_w_mask, m_w_data, m_w_ce, m_inv_ready,
        output mem_ready, mem_rdata,
        input  m_rw_ready, m_r_data, m_inv_valid, m_inv_addr,
        input  mem_valid, mem_addr, mem_we, mem_mask, mem_wdata, mem_ce
    );

endinterface

// File: rtl/sysbus_rr_arbiter.sv
// sysbus_rr_arbiter: picks one requester; round-robin under SYSBUS_RR_ARB_EN, else lowest index wins
module sysbus_rr_arbiter
    import sysbus_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
`ifdef SYSBUS_RR_ARB_EN
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
`endif
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

`ifdef SYSBUS_RR_ARB_EN
    logic [IW-1:0] ptr_q, ptr_d;

    // walk from furthest to nearest so the requester closest to the pointer wins
    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr_q) + i) % N]) begin
                gnt = '0;
                gnt[(int'(ptr_q) + i) % N] = 1'b1;
            end
    end

    assign idx = IW'(oh2idx(32'(gnt)));
    assign ptr_d = adv ? IW'((int'(idx) + 1) % N) : ptr_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
`else
    assign gnt = req & (-req);
    assign idx = IW'(oh2idx(32'(gnt)));
`endif

endmodule

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: serialises cache refills/write-throughs onto one memory port and broadcasts write invalidates; SYSBUS_RR_ARB_EN selects round-robin arbitration
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    localparam int MASKW = WIDTH / 8,
    localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1
) (
    input logic             clk,
    input logic             rst,
    sysbus_arbiter_if.slave bus
);

    state_t                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d, ready_q, ready_d, inv_pend_q, inv_pend_d;
    logic [NUM_MASTERS-1:0]  req, gnt;
    logic [IW-1:0]           idx;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, inv_addr_q, inv_addr_d;
    logic                    we_q, we_d, ce_q, ce_d, valid_q, valid_d;
    logic [MASKW-1:0]        mask_q, mask_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d, rdata_q, rdata_d;

    // a write waits until every invalidate of the previous write is acked; reads never wait
    assign req = bus.m_rw_valid & ~(bus.m_rw_we & {NUM_MASTERS{|inv_pend_q}});

    sysbus_rr_arbiter #(.N(NUM_MASTERS)) u_arb (
`ifdef SYSBUS_RR_ARB_EN
        .clk(clk),
        .rst(rst),
        .adv(state_q == IDLE && |req),
`endif
        .req(req),
        .gnt(gnt),
        .idx(idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        we_d       = we_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        ce_d       = ce_q;
        valid_d    = valid_q;
        rdata_d    = rdata_q;
        inv_addr_d = inv_addr_q;
        ready_d    = '0;
        inv_pend_d = inv_pend_q & ~bus.m_inv_ready;
        case (state_q)
            IDLE: if (|req) begin
                state_d = MEM;
                grant_d = gnt;
                addr_d  = bus.m_rw_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
                we_d    = bus.m_rw_we[idx];
                mask_d  = bus.m_w_mask[int'(idx)*MASKW +: MASKW];
                wdata_d = bus.m_w_data[int'(idx)*WIDTH +: WIDTH];
                ce_d    = bus.m_w_ce[idx];
                valid_d = 1'b1;
            end
            MEM: if (bus.mem_ready) begin
                state_d = RESP;
                valid_d = 1'b0;
                rdata_d = bus.mem_rdata;
                ready_d = grant_q;
                if (we_q) begin
                    inv_pend_d = ~grant_q;
                    inv_addr_d = addr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            mask_q     <= '0;
            wdata_q    <= '0;
            ce_q       <= 1'b0;
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= '0;
            inv_pend_q <= '0;
            inv_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            ce_q       <= ce_d;
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            inv_pend_q <= inv_pend_d;
            inv_addr_q <= inv_addr_d;
        end
    end

    assign bus.m_rw_ready  = ready_q;
    assign bus.m_r_data    = rdata_q;
    assign bus.m_inv_valid = inv_pend_q;
    assign bus.m_inv_addr  = inv_addr_q;
    assign bus.mem_valid   = valid_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_mask    = mask_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_ce      = ce_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: directed scenarios for the system bus arbiter
module tb_sysbus_arbiter;

    localparam int N = 2, W = 128, AW = 32, MW = 16;
    localparam logic [W-1:0] JUNK = {4{32'hA5A5_5A5A}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sysbus_arbiter_if #(.NUM_MASTERS(N), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    sysbus_arbiter #(.NUM_MASTERS(N), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.m_rw_valid  = '0;
        bus.m_rw_addr   = '0;
        bus.m_rw_we     = '0;
        bus.m_w_mask    = '0;
        bus.m_w_data    = '0;
        bus.m_w_ce      = '0;
        bus.m_inv_ready = '0;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = JUNK;
    endtask

    task automatic drive_req(input int m, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.m_rw_valid[m]          = 1'b1;
        bus.m_rw_we[m]             = we;
        bus.m_rw_addr[m*AW +: AW]  = a;
        bus.m_w_data[m*W +: W]     = d;
        bus.m_w_mask[m*MW +: MW]   = 16'hFFFF;
        bus.m_w_ce[m]              = we;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tests++;
        if ({bus.m_rw_ready, bus.m_inv_valid, bus.mem_valid, bus.mem_we, bus.mem_ce} !== 7'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 0", {bus.m_rw_ready, bus.m_inv_valid, bus.mem_valid, bus.mem_we, bus.mem_ce});
        end
        tests++;
        if ({bus.m_r_data, bus.m_inv_addr} !== '0) begin
            fails++;
            $display("FAIL reset_rdata_inv: got %h expected 0", {bus.m_r_data, bus.m_inv_addr});
        end
        tests++;
        if ({bus.mem_addr, bus.mem_mask, bus.mem_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_mem: got %h expected 0", {bus.mem_addr, bus.mem_mask, bus.mem_wdata});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read;
        logic [W-1:0] rd = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
        drive_req(0, 1'b0, 32'h0000_1000, '0);
        tick();
        tests++;
        if ({bus.mem_valid, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h0000_1000}) begin
            fails++;
            $display("FAIL read_issue: got v=%b we=%b a=%h expected v=1 we=0 a=00001000", bus.mem_valid, bus.mem_we, bus.mem_addr);
        end
        bus.m_rw_valid = '0;
        tick();
        tests++;
        if ({bus.mem_valid, bus.mem_addr, bus.m_rw_ready} !== {1'b1, 32'h0000_1000, 2'b00}) begin
            fails++;
            $display("FAIL read_hold: got v=%b a=%h rdy=%b expected v=1 a=00001000 rdy=00", bus.mem_valid, bus.mem_addr, bus.m_rw_ready);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = JUNK;
        tests++;
        if ({bus.m_rw_ready, bus.mem_valid, bus.m_inv_valid} !== {2'b01, 1'b0, 2'b00}) begin
            fails++;
            $display("FAIL read_ready: got rdy=%b v=%b inv=%b expected rdy=01 v=0 inv=00", bus.m_rw_ready, bus.mem_valid, bus.m_inv_valid);
        end
        tests++;
        if (bus.m_r_data !== rd) begin
            fails++;
            $display("FAIL read_data: got %h expected %h", bus.m_r_data, rd);
        end
        tick();
        tests++;
        if ({bus.m_rw_ready, bus.mem_valid, bus.m_inv_valid} !== 5'd0) begin
            fails++;
            $display("FAIL read_pulse_end: got rdy=%b v=%b inv=%b expected all 0", bus.m_rw_ready, bus.mem_valid, bus.m_inv_valid);
        end
    endtask

    task automatic test_write;
        logic [W-1:0] wd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        drive_req(1, 1'b1, 32'h0000_2040, wd);
        tick();
        tests++;
        if ({bus.mem_valid, bus.mem_we, bus.mem_ce, bus.mem_addr, bus.mem_mask} !== {3'b111, 32'h0000_2040, 16'hFFFF}) begin
            fails++;
            $display("FAIL write_issue: got v=%b we=%b ce=%b a=%h m=%h expected 1 1 1 00002040 ffff", bus.mem_valid, bus.mem_we, bus.mem_ce, bus.mem_addr, bus.mem_mask);
        end
        tests++;
        if (bus.mem_wdata !== wd) begin
            fails++;
            $display("FAIL write_data: got %h expected %h", bus.mem_wdata, wd);
        end
        bus.m_rw_valid = '0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tests++;
        if ({bus.m_rw_ready, bus.m_inv_valid, bus.m_inv_addr} !== {2'b10, 2'b01, 32'h0000_2040}) begin
            fails++;
            $display("FAIL write_ready_inv: got rdy=%b inv=%b ia=%h expected rdy=10 inv=01 ia=00002040", bus.m_rw_ready, bus.m_inv_valid, bus.m_inv_addr);
        end
        tick();
        tick();
        bus.m_inv_ready = 2'b10;
        tick();
        tests++;
        if ({bus.m_rw_ready, bus.m_inv_valid} !== {2'b00, 2'b01}) begin
            fails++;
            $display("FAIL inv_hold: got rdy=%b inv=%b expected rdy=00 inv=01", bus.m_rw_ready, bus.m_inv_valid);
        end
        bus.m_inv_ready = 2'b01;
        tick();
        bus.m_inv_ready = 2'b00;
        tests++;
        if (bus.m_inv_valid !== 2'b00) begin
            fails++;
            $display("FAIL inv_ack: got %b expected 00", bus.m_inv_valid);
        end
    endtask

    task automatic test_arbitration;
        int exp_m;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drive_req(0, 1'b0, 32'h0000_0100, '0);
        drive_req(1, 1'b0, 32'h0000_0200, '0);
        for (int k = 0; k < 4; k++) begin
`ifdef SYSBUS_RR_ARB_EN
            exp_m = k % 2;
`else
            exp_m = 0;
`endif
            tick();
            tests++;
            if ({bus.mem_valid, bus.mem_addr} !== {1'b1, (exp_m == 1) ? 32'h0000_0200 : 32'h0000_0100}) begin
                fails++;
                $display("FAIL arb_grant%0d: got v=%b a=%h expected master %0d", k, bus.mem_valid, bus.mem_addr, exp_m);
            end
            bus.mem_ready = 1'b1;
            tick();
            bus.mem_ready = 1'b0;
            tests++;
            if (bus.m_rw_ready !== ((exp_m == 1) ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL arb_ready%0d: got %b expected master %0d", k, bus.m_rw_ready, exp_m);
            end
            tick();
        end
        bus.m_rw_valid = '0;
        tick();
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        drive_req(0, 1'b0, 32'h0000_0300, '0);
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (bus.m_rw_ready[0]) pulses++;
        end
        bus.m_rw_valid = '0;
        bus.mem_ready = 1'b0;
        tests++;
        if (pulses !== 3) begin
            fails++;
            $display("FAIL b2b_rate: got %0d pulses expected 3", pulses);
        end
        tick();
        tick();
    endtask

    task automatic test_inv_outstanding;
        logic [W-1:0] rd = 128'h1234_0000_0000_0000_0000_0000_0000_5678;
        drive_req(1, 1'b1, 32'h0000_3000, '1);
        tick();
        bus.m_rw_valid = '0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        drive_req(0, 1'b0, 32'h0000_4000, '0);
        tick();
        tests++;
        if ({bus.mem_valid, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h0000_4000}) begin
            fails++;
            $display("FAIL inv_read_issue: got v=%b we=%b a=%h expected v=1 we=0 a=00004000", bus.mem_valid, bus.mem_we, bus.mem_addr);
        end
        bus.m_rw_valid = '0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = JUNK;
        tests++;
        if ({bus.m_rw_ready, bus.m_inv_valid, bus.m_r_data} !== {2'b01, 2'b01, rd}) begin
            fails++;
            $display("FAIL inv_read_done: got rdy=%b inv=%b d=%h expected rdy=01 inv=01 d=%h", bus.m_rw_ready, bus.m_inv_valid, bus.m_r_data, rd);
        end
        tick();
        drive_req(1, 1'b1, 32'h0000_5000, '1);
        tick();
        tick();
        tick();
        tests++;
        if ({bus.mem_valid, bus.m_inv_valid} !== {1'b0, 2'b01}) begin
            fails++;
            $display("FAIL write_blocked: got v=%b inv=%b expected v=0 inv=01", bus.mem_valid, bus.m_inv_valid);
        end
        bus.m_inv_ready = 2'b01;
        tick();
        bus.m_inv_ready = 2'b00;
        tick();
        tests++;
        if ({bus.mem_valid, bus.mem_we, bus.mem_addr} !== {2'b11, 32'h0000_5000}) begin
            fails++;
            $display("FAIL write_released: got v=%b we=%b a=%h expected v=1 we=1 a=00005000", bus.mem_valid, bus.mem_we, bus.mem_addr);
        end
        bus.m_rw_valid = '0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tests++;
        if ({bus.m_rw_ready, bus.m_inv_valid, bus.m_inv_addr} !== {2'b10, 2'b01, 32'h0000_5000}) begin
            fails++;
            $display("FAIL write2_inv: got rdy=%b inv=%b ia=%h expected rdy=10 inv=01 ia=00005000", bus.m_rw_ready, bus.m_inv_valid, bus.m_inv_addr);
        end
        bus.m_inv_ready = 2'b01;
        tick();
        bus.m_inv_ready = 2'b00;
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] rd = 128'hCAFE_0000_0000_0000_0000_0000_0000_F00D;
        drive_req(1, 1'b1, 32'h0000_7000, '1);
        tick();
        bus.m_rw_valid = '0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        drive_req(0, 1'b0, 32'h0000_8000, '0);
        tick();
        rst = 1'b1;
        #1;
        bus.m_rw_valid = '0;
        tests++;
        if ({bus.m_rw_ready, bus.m_inv_valid, bus.mem_valid, bus.mem_we, bus.mem_ce} !== 7'd0) begin
            fails++;
            $display("FAIL midreset_ctrl: got %b expected 0", {bus.m_rw_ready, bus.m_inv_valid, bus.mem_valid, bus.mem_we, bus.mem_ce});
        end
        tests++;
        if ({bus.mem_addr, bus.mem_mask, bus.mem_wdata, bus.m_r_data, bus.m_inv_addr} !== '0) begin
            fails++;
            $display("FAIL midreset_data: got %h expected 0", {bus.mem_addr, bus.m_inv_addr});
        end
        tick();
        rst = 1'b0;
        drive_req(0, 1'b0, 32'h0000_6000, '0);
        tick();
        tests++;
        if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 32'h0000_6000}) begin
            fails++;
            $display("FAIL postreset_issue: got v=%b a=%h expected v=1 a=00006000", bus.mem_valid, bus.mem_addr);
        end
        bus.m_rw_valid = '0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = JUNK;
        tests++;
        if ({bus.m_rw_ready, bus.m_inv_valid, bus.m_r_data} !== {2'b01, 2'b00, rd}) begin
            fails++;
            $display("FAIL postreset_done: got rdy=%b inv=%b d=%h expected rdy=01 inv=00 d=%h", bus.m_rw_ready, bus.m_inv_valid, bus.m_r_data, rd);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_arbitration();
        test_back_to_back();
        test_inv_outstanding();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shared SystemBus interconnect that sits directly downstream of the per-core snoopy read-only caches.
- Arbitrates their read (refill) and write-through requests onto a single memory port.
- Returns read data to the requester.
- On every completed write, broadcasts an invalidate to all other masters so their cached copies are dropped.

Parameters:
- NUM_MASTERS, 2, number of cache ports on the bus.
- WIDTH, 128, data line width in bits.
- MASKW, WIDTH/8, byte-enable width.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- m_rw_valid  in  NUM_MASTERS  per-master request valid
- m_rw_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master address
- m_rw_we  in  NUM_MASTERS  1 = write, 0 = read
- m_w_mask  in  NUM_MASTERS*MASKW  per-master byte enables
- m_w_data  in  NUM_MASTERS*WIDTH  per-master write data
- m_w_ce  in  NUM_MASTERS  write chip-enable, forwarded to memory
- m_rw_ready  out  NUM_MASTERS  one-cycle completion pulse, per master
- m_r_data  out  WIDTH  read data, common to all masters; valid while any m_rw_ready bit is high
- m_inv_valid  out  NUM_MASTERS  invalidate request, per master
- m_inv_addr  out  ADDR_WIDTH  invalidate address, common to all masters
- m_inv_ready  in  NUM_MASTERS  invalidate acknowledge, per master
- mem_valid  out  1  memory request
- mem_addr  out  ADDR_WIDTH  memory address
- mem_we  out  1  memory write
- mem_mask  out  MASKW  memory byte enables
- mem_wdata  out  WIDTH  memory write data
- mem_ce  out  1  memory chip-enable
- mem_ready  in  1  memory done; mem_rdata is valid in the same cycle
- mem_rdata  in  WIDTH  memory read data

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; grant = 0; arbitration pointer = 0; inv_pend = 0.
  - All outputs 0: m_rw_ready, m_r_data, m_inv_valid, m_inv_addr, mem_*.
- Main FSM states: IDLE, MEM, RESP.
- IDLE:
  - Candidate set = masters with m_rw_valid=1.
  - A write candidate is masked while inv_pend != 0. Reads are never masked.
  - If the masked set is non-empty: select a master (see Optional Feature), latch grant, addr, we, mask, wdata, ce; go to MEM. Selection takes one cycle.
- MEM:
  - Drive mem_valid=1 plus the latched fields; all fields stay stable until mem_ready.
  - On mem_ready: latch mem_rdata into rdata_q. If the request was a write, load inv_addr=addr and inv_pend = all-ones with the grant bit cleared. Go to RESP.
- RESP:
  - m_rw_ready[grant]=1 for exactly one cycle; m_r_data=rdata_q. Then return to IDLE.
  - Back-to-back requests from the same master are served with a minimum of 3 cycles per request.
- Invalidate engine (independent of the main FSM):
  - m_inv_valid = inv_pend; m_inv_addr = inv_addr.
  - inv_pend[i] clears in the cycle m_inv_ready[i]=1 is seen. m_inv_ready without a matching pend bit is ignored.
  - Reads keep being served while invalidates are outstanding. A cache in refill defers its invalidate ack until the refill completes, so blocking reads here would deadlock.
  - A refill that completes after the write reaches memory gets fresh data. A late invalidate of that line is harmless (extra miss).
- Edge cases:
  - NUM_MASTERS=1: inv_pend is always 0 and no invalidate is ever issued.
  - The requester never receives its own invalidate.
  - m_rw_valid dropped mid-transaction: the latched request completes anyway; the ready pulse is still issued.
  - Reset mid-MEM: memory request abandoned, pending invalidates dropped.

Optional Feature:
- Macro: SYSBUS_RR_ARB_EN.
- Defined: round-robin arbitration. Search starts at the arbitration pointer; after each grant the pointer = grant+1 mod NUM_MASTERS. No master waits more than NUM_MASTERS-1 grants.
- Undefined: fixed priority, lowest index wins; the pointer register is not instantiated.

Decomposition:
- Package sysbus_pkg holds the main FSM state enum, the default width constants (WIDTH, ADDR_WIDTH), and a helper function for the one-hot-to-index conversion.
- One sub-module, sysbus_rr_arbiter: request vector in; one-hot grant and index out. Holds the pointer register when SYSBUS_RR_ARB_EN is defined.

Test Plan:
- Single read, master 0, addr 0x0000_1000; memory returns 0xDEAD..BEEF after 2 cycles -> m_rw_ready[0] pulses once, m_r_data = 0xDEAD..BEEF, no m_inv_valid.
- Write from master 1, addr 0x0000_2040, mask 0xFFFF -> mem_we=1 with matching data; after mem_ready, m_rw_ready[1] pulses and m_inv_valid=2'b01 with m_inv_addr=0x0000_2040, held until m_inv_ready[0].
- Master 0 and master 1 reads held continuously, SYSBUS_RR_ARB_EN defined -> grants alternate 0,1,0,1. Without the macro -> master 0 is served every time.
- Inv to master 0 outstanding (no ack) while master 0 issues a read -> read completes and the invalidate stays asserted. A second write from master 1 is held until master 0 acks.
- Assert rst during MEM with inv_pend=2'b01 -> all outputs 0 immediately; the next request starts cleanly from IDLE.
